aula_20201105_qsys_key_ic: RTL
==============================

AULA_20201105_QSYS_KEY_IC -- requirements
Module: aula_20201105_qsys_key_ic

Interface
REQ-001 Parameter WIDTH, default 4: number of key inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles before a new key level is accepted (1 ms at 50 MHz).
REQ-003 One clock and one reset: reset_n is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 address  input  2  Avalon-MM word offset.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 read_n  input  1  active-low read strobe.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  raw asynchronous key levels, active-low (pressed = 0).
REQ-012 readdata  output  32  read data, valid one cycle after the read strobe.
REQ-013 irq  output  1  level interrupt request, active-high.

Function
REQ-014 Each in_port bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Per bit, the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the debounced value resets that bit's counter to 0.
REQ-016 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter saturates at DEBOUNCE_CYCLES and never wraps.
REQ-017 Input-to-debounced latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean level change.
REQ-018 Register map: offset 0 data (RO, debounced levels zero-extended); offset 1 reserved (reads 0, writes ignored); offset 2 irq_mask (RW, WIDTH bits); offset 3 edge_capture (RW1C).
REQ-019 A write occurs when chipselect=1 and write_n=0; it SHALL update the register in the same cycle, visible on the next cycle.
REQ-020 A read occurs when chipselect=1 and read_n=0; readdata SHALL be registered, 1-cycle read latency, upper 32-WIDTH bits 0.
REQ-021 readdata SHALL hold its last value when no read is in progress.
REQ-022 edge_capture[i] SHALL set on a falling edge (1->0) of debounced bit i, which is a press.
REQ-023 Writing 1 to edge_capture[i] SHALL clear it; writing 0 leaves it unchanged.
REQ-024 If a clear and a new edge hit the same bit in the same cycle, the set SHALL win.
REQ-025 irq SHALL equal OR(edge_capture & irq_mask), registered, asserting 1 cycle after the contributing edge_capture/mask change.
REQ-026 Writes to offset 0 SHALL be ignored.

Reset
REQ-027 On reset_n=0 the block SHALL set: synchronizer flops and debounced levels to all-ones (released); counters, irq_mask, edge_capture, readdata and irq to 0.
REQ-028 Reset mid-debounce SHALL discard the partial count; no edge is generated by reset release.

Structure
REQ-029 A shared package SHALL hold the register offset constants (DATA=0, MASK=2, EDGE=3) and the data width constant 32.
REQ-030 The per-bit synchronizer plus debounce SHALL be a sub-module aula_20201105_qsys_key_ic_debounce, instantiated WIDTH times.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4)
REQ-031 Reset, read offset 0 -> readdata 0x0000000F; irq 0; read offset 3 -> 0x0.
REQ-032 Drive in_port=0xE, hold 10 cycles -> data reads 0xE exactly 6 cycles after the change; edge_capture reads 0x1.
REQ-033 Bit 0 glitches to 0 for 3 cycles then back to 1 -> data stays 0xF; edge_capture stays 0x0.
REQ-034 Write mask=0x1, then press bit 0 -> irq rises 1 cycle after edge_capture bit 0 sets; write 0x1 to offset 3 -> edge_capture 0x0, irq falls the following cycle.
REQ-035 Press bit 1 timed so its edge lands in the same cycle as a write of 0x2 to offset 3 -> edge_capture bit 1 remains 1.
REQ-036 Assert reset_n low while bit 2 is 2 cycles into debounce -> all registers return to reset values; after release with in_port=0xF, no edge captured.

Source files
------------

// File: rtl/aula_20201105_qsys_key_ic_pkg.sv
// Shared constants and types for the key input controller.
// Register offsets follow the Avalon-MM word map.
package aula_20201105_qsys_key_ic_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef struct packed {
        logic              wr;
        logic              rd;
        logic [1:0]        addr;
        logic [DATA_W-1:0] wdata;
    } avl_req_t;

endpackage

// File: rtl/aula_20201105_qsys_key_ic_debounce.sv
// One key bit: 2-flop synchronizer followed by a stable-count debouncer.
// fall_o pulses in the cycle the debounced level is about to drop.
module aula_20201105_qsys_key_ic_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall;

    always_comb begin
        sync1_d = key_i;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        fall    = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            // Last differing cycle: accept the new level this edge.
            cnt_d   = '0;
            level_d = sync2_q;
            fall    = level_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall;

endmodule

// File: rtl/aula_20201105_qsys_key_ic.sv
// Avalon-MM key input controller: debounced levels, press capture
// and a masked level interrupt.
module aula_20201105_qsys_key_ic
    import aula_20201105_qsys_key_ic_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    avl_req_t          req;
    logic [WIDTH-1:0]  level;
    logic [WIDTH-1:0]  fall;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  edge_q, edge_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_wdata;

    assign req.wr    = chipselect & ~write_n;
    assign req.rd    = chipselect & ~read_n;
    assign req.addr  = address;
    assign req.wdata = writedata;

    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_key
        aula_20201105_qsys_key_ic_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .key_i  (in_port[i]),
            .level_o(level[i]),
            .fall_o (fall[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        unique case (req.addr)
            ADDR_DATA: rd_mux[WIDTH-1:0] = level;
            ADDR_RSVD: rd_mux = '0;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_q;
        endcase
    end

    always_comb begin
        mask_d  = mask_q;
        edge_d  = edge_q;
        rdata_d = rdata_q;
        if (req.wr && req.addr == ADDR_MASK) begin
            mask_d = req.wdata[WIDTH-1:0];
        end
        if (req.wr && req.addr == ADDR_EDGE) begin
            edge_d = edge_q & ~req.wdata[WIDTH-1:0];
        end
        // A press arriving with a clear of the same bit keeps the bit set.
        edge_d = edge_d | fall;
        if (req.rd) begin
            rdata_d = rd_mux;
        end
        irq_d = |(edge_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q  <= '0;
            edge_q  <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule
